// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the ARM pipeline memory stage: register/address widths,
// the data-memory base address and the MEM/WB bundle layout.
package mem_stage_ctrl_pkg;

    localparam int unsigned ADDRESS_LEN     = 32;
    localparam int unsigned REGISTER_LEN    = 32;
    localparam int unsigned REG_ADDRESS_LEN = 4;
    localparam logic [ADDRESS_LEN-1:0] DATA_MEM_BASE = 32'd1024;

    typedef struct packed {
        logic                       wb_en;
        logic                       mem_r_en;
        logic [REG_ADDRESS_LEN-1:0] dest;
        logic [REGISTER_LEN-1:0]    alu_res;
    } wb_bundle_t;

    // Byte address to data-memory word index; underflow wraps.
    function automatic logic [ADDRESS_LEN-1:0] word_addr(
        input logic [ADDRESS_LEN-1:0] byte_addr,
        input logic [ADDRESS_LEN-1:0] base
    );
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_wb_reg.sv
// MEM/WB pipeline register: loads the bundle every cycle, or a bubble
// (write-back and load flags cleared) while the stage is frozen.
module mem_wb_reg
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = REGISTER_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze_i,
    input  wb_bundle_t        bundle_i,
    input  logic              data_load_i,
    input  logic [DATA_W-1:0] data_i,
    output wb_bundle_t        bundle_o,
    output logic [DATA_W-1:0] data_o
);

    wb_bundle_t        bundle_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= '0;
            data_q   <= '0;
        end else begin
            if (freeze_i) begin
                // Bubble: only the flags matter, the payload keeps its old value.
                bundle_q.wb_en    <= 1'b0;
                bundle_q.mem_r_en <= 1'b0;
            end else begin
                bundle_q <= bundle_i;
            end
            if (data_load_i) begin
                data_q <= data_i;
            end
        end
    end

    assign bundle_o = bundle_q;
    assign data_o   = data_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: runs loads/stores over a req/ack handshake, freezes upstream while
// an access is outstanding. Optional access timeout under MEM_TIMEOUT_EN.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W         = REGISTER_LEN,
    parameter int unsigned MEM_ADDR_W     = 16,
    parameter logic [31:0] BASE_ADDR      = DATA_MEM_BASE,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_en_in,
    input  logic                       mem_r_en_in,
    input  logic                       mem_w_en_in,
    input  logic [DATA_W-1:0]          alu_res_in,
    input  logic [DATA_W-1:0]          val_Rm_in,
    input  logic [REG_ADDRESS_LEN-1:0] dest_in,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [MEM_ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_ack,
    output logic                       freeze,
    output logic                       wb_en_out,
    output logic                       mem_r_en_out,
    output logic [REG_ADDRESS_LEN-1:0] dest_out,
    output logic [DATA_W-1:0]          alu_res_out,
    output logic [DATA_W-1:0]          mem_data_out,
    output logic                       mem_err
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    mem_state_e        state_q;
    logic              mem_op_c;
    logic              access_c;
    logic              ack_c;
    logic              timeout_c;
    logic              done_c;
    logic              data_load_c;
    logic [DATA_W-1:0] data_c;
    wb_bundle_t        bundle_c;
    wb_bundle_t        bundle_out;

    assign mem_op_c = mem_r_en_in | mem_w_en_in;
    assign access_c = (state_q == ST_ACCESS);
    assign ack_c    = access_c & mem_ack;
    assign done_c   = ack_c | timeout_c;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic             mem_err_q;

    assign timeout_c = access_c & ~mem_ack & (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts unacknowledged ACCESS cycles; zero whenever no access is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= timeout_c;
            if (access_c && !done_c) begin
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign mem_err = mem_err_q;
`else
    logic [31:0] unused_timeout_cfg;

    // The limit only matters when the timeout counter is built.
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign timeout_c          = 1'b0;
    assign mem_err            = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (mem_op_c) state_q <= ST_ACCESS;
                ST_ACCESS: if (done_c)   state_q <= ST_IDLE;
                default:                 state_q <= ST_IDLE;
            endcase
        end
    end

    // Request comes straight from the state register so reset kills it at once.
    assign mem_req   = access_c;
    assign mem_we    = access_c & mem_w_en_in;
    assign mem_addr  = MEM_ADDR_W'(word_addr(ADDRESS_LEN'(alu_res_in), ADDRESS_LEN'(BASE_ADDR)));
    assign mem_wdata = val_Rm_in;
    assign freeze    = mem_op_c & ~done_c;

    // A simultaneous read and write is a store, so it never captures read data.
    assign data_load_c = (ack_c & mem_r_en_in & ~mem_w_en_in) | timeout_c;
    assign data_c      = timeout_c ? '0 : mem_rdata;

    assign bundle_c.wb_en    = wb_en_in;
    assign bundle_c.mem_r_en = mem_r_en_in;
    assign bundle_c.dest     = dest_in;
    assign bundle_c.alu_res  = REGISTER_LEN'(alu_res_in);

    mem_wb_reg #(
        .DATA_W (DATA_W)
    ) u_mem_wb_reg (
        .clk         (clk),
        .rst         (rst),
        .freeze_i    (freeze),
        .bundle_i    (bundle_c),
        .data_load_i (data_load_c),
        .data_i      (data_c),
        .bundle_o    (bundle_out),
        .data_o      (mem_data_out)
    );

    assign wb_en_out    = bundle_out.wb_en;
    assign mem_r_en_out = bundle_out.mem_r_en;
    assign dest_out     = bundle_out.dest;
    assign alu_res_out  = DATA_W'(bundle_out.alu_res);

endmodule
